projectile_bank: RTL and testbench



---
 rtl/projectile_bank.sv | 235 +++++++++++++++++++++++
 tb/tb_projectile_bank.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/projectile_bank.sv
// rtl/projectile_bank.sv - multi-slot projectile physics engine with boom event queue and sprite query
// Optional feature macro: PROJ_WIND_EN (adds signed wind input applied on every gravity step).
module projectile_bank #(
    parameter int N_PROJ      = 4,
    parameter int COORD_W     = 10,
    parameter int V_MAX       = 12,
    parameter int GRAV_PERIOD = 6,
    parameter int X_MIN       = 5,
    parameter int X_MAX       = 634,
    parameter int Y_MIN       = 5,
    parameter int Y_MAX       = 474,
    parameter int SPR_W       = 12,
    parameter int SPR_H       = 17,
    parameter int CX          = 5,
    parameter int CY          = 9
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        frame_tick,
    input  logic                        launch_valid,
    output logic                        launch_ready,
    input  logic [COORD_W-1:0]          launch_x,
    input  logic [COORD_W-1:0]          launch_y,
    input  logic [COORD_W-1:0]          launch_vx,
    input  logic [COORD_W-1:0]          launch_vy,
    input  logic [N_PROJ-1:0]           hit,
`ifdef PROJ_WIND_EN
    input  logic signed [3:0]           wind,
`endif
    output logic [N_PROJ-1:0]           active,
    output logic [N_PROJ*COORD_W-1:0]   slot_x,
    output logic [N_PROJ*COORD_W-1:0]   slot_y,
    output logic                        boom_valid,
    input  logic                        boom_ready,
    output logic [COORD_W-1:0]          boom_x,
    output logic [COORD_W-1:0]          boom_y,
    output logic [2:0]                  boom_slot,
    input  logic [COORD_W-1:0]          draw_x,
    input  logic [COORD_W-1:0]          draw_y,
    output logic                        draw_bomb,
    output logic [2:0]                  draw_slot,
    output logic [17:0]                 addr_bomb
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FLIGHT = 2'd1;
    localparam logic [1:0] ST_BOOM   = 2'd2;

    localparam logic signed [COORD_W:0]   V_HI    = (COORD_W+1)'(V_MAX);
    localparam logic signed [COORD_W:0]   V_LO    = -V_HI;
    localparam logic signed [COORD_W:0]   ONE_W   = (COORD_W+1)'(1);
    localparam logic [7:0]                GP_LAST = 8'(GRAV_PERIOD-1);
    localparam logic [COORD_W-1:0]        X_LO    = COORD_W'(X_MIN+CX);
    localparam logic [COORD_W-1:0]        X_HI    = COORD_W'(X_MAX-SPR_W+CX);
    localparam logic [COORD_W-1:0]        Y_LO    = COORD_W'(Y_MIN+CY);
    localparam logic [COORD_W-1:0]        Y_HI    = COORD_W'(Y_MAX-SPR_H+CY);
    localparam logic signed [COORD_W+1:0] CX_S    = (COORD_W+2)'(CX);
    localparam logic signed [COORD_W+1:0] CY_S    = (COORD_W+2)'(CY);
    localparam logic signed [COORD_W+1:0] SW_S    = (COORD_W+2)'(SPR_W);
    localparam logic signed [COORD_W+1:0] SH_S    = (COORD_W+2)'(SPR_H);
    localparam logic signed [COORD_W+1:0] ZERO_S  = '0;
    localparam logic [17:0]               SPR_W18 = 18'(SPR_W);

    logic [1:0]                state [N_PROJ];
    logic [COORD_W-1:0]        px    [N_PROJ];
    logic [COORD_W-1:0]        py    [N_PROJ];
    logic signed [COORD_W-1:0] vx    [N_PROJ];
    logic signed [COORD_W-1:0] vy    [N_PROJ];
    logic [7:0]                gcnt  [N_PROJ];

    logic [N_PROJ-1:0]         oob;
    logic [N_PROJ-1:0]         in_box;
    logic signed [COORD_W+1:0] dx [N_PROJ];
    logic signed [COORD_W+1:0] dy [N_PROJ];

    logic       launch_fire;
    logic [2:0] launch_idx;
    logic       boom_any;
    logic [2:0] boom_low;
    logic [2:0] boom_sel;
    logic       boom_fire;
    logic       lock_valid;
    logic [2:0] lock_slot;

    function automatic logic signed [COORD_W-1:0] clamp_v(input logic signed [COORD_W:0] v);
        if (v > V_HI)
            return V_HI[COORD_W-1:0];
        else if (v < V_LO)
            return V_LO[COORD_W-1:0];
        else
            return v[COORD_W-1:0];
    endfunction

    // Lowest-index IDLE slot takes the launch; lowest-index BOOM slot is the candidate event.
    always_comb begin
        launch_ready = 1'b0;
        launch_idx   = 3'd0;
        boom_any     = 1'b0;
        boom_low     = 3'd0;
        for (int i = 0; i < N_PROJ; i++) begin
            if (!launch_ready && state[i] == ST_IDLE) begin
                launch_ready = 1'b1;
                launch_idx   = 3'(i);
            end
            if (!boom_any && state[i] == ST_BOOM) begin
                boom_any = 1'b1;
                boom_low = 3'(i);
            end
        end
    end

    assign launch_fire = launch_valid && launch_ready;

    // Once presented, an event is pinned so a later lower-index boom cannot swap it under backpressure.
    assign boom_sel   = lock_valid ? lock_slot : boom_low;
    assign boom_valid = boom_any;
    assign boom_fire  = boom_valid && boom_ready;

    always_comb begin
        boom_slot = 3'd0;
        boom_x    = '0;
        boom_y    = '0;
        if (boom_valid) begin
            boom_slot = boom_sel;
            for (int i = 0; i < N_PROJ; i++) begin
                if (boom_sel == 3'(i)) begin
                    boom_x = px[i];
                    boom_y = py[i];
                end
            end
        end
    end

    always_comb begin
        oob    = '0;
        active = '0;
        slot_x = '0;
        slot_y = '0;
        for (int i = 0; i < N_PROJ; i++) begin
            oob[i]    = (px[i] <= X_LO) || (px[i] >= X_HI) || (py[i] <= Y_LO) || (py[i] >= Y_HI);
            active[i] = (state[i] == ST_FLIGHT);
            slot_x[i*COORD_W +: COORD_W] = px[i];
            slot_y[i*COORD_W +: COORD_W] = py[i];
        end
    end

    // Sprite box test done in two extra bits of signed range so boxes near 0 do not wrap.
    always_comb begin
        in_box    = '0;
        draw_bomb = 1'b0;
        draw_slot = 3'd0;
        addr_bomb = 18'd0;
        for (int i = 0; i < N_PROJ; i++) begin
            dx[i] = $signed({2'b00, draw_x}) - ($signed({2'b00, px[i]}) - CX_S);
            dy[i] = $signed({2'b00, draw_y}) - ($signed({2'b00, py[i]}) - CY_S);
            in_box[i] = (state[i] == ST_FLIGHT) && (dx[i] >= ZERO_S) && (dx[i] < SW_S)
                        && (dy[i] >= ZERO_S) && (dy[i] < SH_S);
        end
        for (int i = 0; i < N_PROJ; i++) begin
            if (!draw_bomb && in_box[i]) begin
                draw_bomb = 1'b1;
                draw_slot = 3'(i);
                addr_bomb = 18'($unsigned(dy[i])) * SPR_W18 + 18'($unsigned(dx[i]));
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_valid <= 1'b0;
            lock_slot  <= 3'd0;
        end else if (boom_fire) begin
            lock_valid <= 1'b0;
        end else if (boom_valid) begin
            lock_valid <= 1'b1;
            lock_slot  <= boom_sel;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_PROJ; i++) begin
                state[i] <= ST_IDLE;
                px[i]    <= '0;
                py[i]    <= '0;
                vx[i]    <= '0;
                vy[i]    <= '0;
                gcnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N_PROJ; i++) begin
                case (state[i])
                    ST_IDLE: begin
                        if (launch_fire && launch_idx == 3'(i)) begin
                            state[i] <= ST_FLIGHT;
                            px[i]    <= launch_x;
                            py[i]    <= launch_y;
                            vx[i]    <= clamp_v($signed({launch_vx[COORD_W-1], launch_vx}));
                            vy[i]    <= clamp_v($signed({launch_vy[COORD_W-1], launch_vy}));
                            gcnt[i]  <= '0;
                        end
                    end
                    ST_FLIGHT: begin
                        if (frame_tick) begin
                            if (hit[i] || oob[i]) begin
                                state[i] <= ST_BOOM;
                                vx[i]    <= '0;
                                vy[i]    <= '0;
                            end else begin
                                px[i] <= px[i] + $unsigned(vx[i]);
                                py[i] <= py[i] + $unsigned(vy[i]);
                                if (gcnt[i] == GP_LAST) begin
                                    vy[i]   <= clamp_v($signed({vy[i][COORD_W-1], vy[i]}) + ONE_W);
                                    gcnt[i] <= '0;
`ifdef PROJ_WIND_EN
                                    vx[i]   <= clamp_v($signed({vx[i][COORD_W-1], vx[i]})
                                                       + (COORD_W+1)'(wind));
`endif
                                end else begin
                                    gcnt[i] <= gcnt[i] + 8'd1;
                                end
                            end
                        end
                    end
                    ST_BOOM: begin
                        if (boom_fire && boom_sel == 3'(i))
                            state[i] <= ST_IDLE;
                    end
                    default: state[i] <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_projectile_bank.sv
// tb/tb_projectile_bank.sv - scoreboard bench for projectile_bank (boom events checked by a monitor)
module tb_projectile_bank;

    localparam int W = 10;
    localparam int N = 4;

    logic           clk;
    logic           reset_n;
    logic           frame_tick;
    logic           launch_valid;
    logic           launch_ready;
    logic [W-1:0]   launch_x, launch_y, launch_vx, launch_vy;
    logic [N-1:0]   hit;
`ifdef PROJ_WIND_EN
    logic signed [3:0] wind;
`endif
    logic [N-1:0]   active;
    logic [N*W-1:0] slot_x, slot_y;
    logic           boom_valid;
    logic           boom_ready;
    logic [W-1:0]   boom_x, boom_y;
    logic [2:0]     boom_slot;
    logic [W-1:0]   draw_x, draw_y;
    logic           draw_bomb;
    logic [2:0]     draw_slot;
    logic [17:0]    addr_bomb;

    typedef struct {
        logic [2:0]   s;
        logic [W-1:0] x;
        logic [W-1:0] y;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  checks = 0;
    int  errors = 0;

    projectile_bank dut (
        .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
        .launch_valid(launch_valid), .launch_ready(launch_ready),
        .launch_x(launch_x), .launch_y(launch_y), .launch_vx(launch_vx), .launch_vy(launch_vy),
        .hit(hit),
`ifdef PROJ_WIND_EN
        .wind(wind),
`endif
        .active(active), .slot_x(slot_x), .slot_y(slot_y),
        .boom_valid(boom_valid), .boom_ready(boom_ready),
        .boom_x(boom_x), .boom_y(boom_y), .boom_slot(boom_slot),
        .draw_x(draw_x), .draw_y(draw_y),
        .draw_bomb(draw_bomb), .draw_slot(draw_slot), .addr_bomb(addr_bomb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    always @(negedge clk) begin
        if (reset_n && boom_valid && boom_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL boom_unexpected got slot=%0d x=%0d y=%0d want=no_event", boom_slot, boom_x, boom_y);
            end else begin
                mon_e = exp_q.pop_front();
                if (boom_slot !== mon_e.s || boom_x !== mon_e.x || boom_y !== mon_e.y) begin
                    errors++;
                    $display("FAIL boom_event got slot=%0d x=%0d y=%0d want slot=%0d x=%0d y=%0d",
                             boom_slot, boom_x, boom_y, mon_e.s, mon_e.x, mon_e.y);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] sx(input int i);
        return slot_x[i*W +: W];
    endfunction

    function automatic logic [W-1:0] sy(input int i);
        return slot_y[i*W +: W];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [N-1:0] h);
        hit = h;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        hit = '0;
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) begin
            frame('0);
            step();
        end
    endtask

    task automatic launch(input int x, input int y, input int vx, input int vy);
        launch_valid = 1'b1;
        launch_x = W'(x);
        launch_y = W'(y);
        launch_vx = W'(vx);
        launch_vy = W'(vy);
        step();
        launch_valid = 1'b0;
    endtask

    task automatic push_ev(input int s, input int x, input int y);
        ev_t e;
        e.s = 3'(s);
        e.x = W'(x);
        e.y = W'(y);
        exp_q.push_back(e);
    endtask

    initial begin
        reset_n = 1'b0;
        frame_tick = 1'b0;
        launch_valid = 1'b0;
        launch_x = '0; launch_y = '0; launch_vx = '0; launch_vy = '0;
        hit = '0;
`ifdef PROJ_WIND_EN
        wind = 4'sd0;
`endif
        boom_ready = 1'b1;
        draw_x = '0;
        draw_y = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_active", 32'(active), 0);
        chk("rst_boom_valid", 32'(boom_valid), 0);
        chk("rst_draw_bomb", 32'(draw_bomb), 0);
        chk("rst_slot_x", 32'(slot_x[W-1:0]), 0);
        reset_n = 1'b1;
        step();
        chk("rst_launch_ready", 32'(launch_ready), 1);

        // gravity and motion
        launch(100, 200, 3, -5);
        chk("g_active", 32'(active), 1);
        chk("g_x0", 32'(sx(0)), 100);
        chk("g_y0", 32'(sy(0)), 200);
        draw_x = 10'd95;  draw_y = 10'd191; #1;
        chk("draw_tl_hit", 32'(draw_bomb), 1);
        chk("draw_tl_addr", 32'(addr_bomb), 0);
        draw_x = 10'd106; draw_y = 10'd207; #1;
        chk("draw_br_hit", 32'(draw_bomb), 1);
        chk("draw_br_addr", 32'(addr_bomb), 203);
        draw_x = 10'd107; #1;
        chk("draw_right_miss", 32'(draw_bomb), 0);
        chk("draw_miss_addr", 32'(addr_bomb), 0);
        draw_x = 10'd94; draw_y = 10'd200; #1;
        chk("draw_left_miss", 32'(draw_bomb), 0);
        frames(6);
        chk("g_x6", 32'(sx(0)), 118);
        chk("g_y6", 32'(sy(0)), 170);
        frames(1);
        chk("g_x7", 32'(sx(0)), 121);
        chk("g_y7", 32'(sy(0)), 166);
        push_ev(0, 121, 166);
        frame(4'b0001);
        chk("g_boom_valid", 32'(boom_valid), 1);
        chk("g_active_off", 32'(active), 0);
        step();
        chk("g_boom_clear", 32'(boom_valid), 0);

        // velocity clamp
        launch(300, 300, 20, -20);
        frames(1);
        chk("c_x", 32'(sx(0)), 312);
        chk("c_y", 32'(sy(0)), 288);
        push_ev(0, 312, 288);
        frame(4'b0001);
        step();

        // left-edge boom
        launch(14, 200, -3, 0);
        frame('0);
        chk("e_x1", 32'(sx(0)), 11);
        step();
        frame('0);
        chk("e_x2", 32'(sx(0)), 8);
        step();
        push_ev(0, 8, 200);
        frame('0);
        chk("e_boom_valid", 32'(boom_valid), 1);
        chk("e_boom_x", 32'(boom_x), 8);
        chk("e_boom_slot", 32'(boom_slot), 0);
        chk("e_active", 32'(active), 0);
        step();

        // slot exhaustion
        launch_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
            launch_x = W'(100 + 50*i);
            launch_y = 10'd200;
            launch_vx = '0;
            launch_vy = '0;
            step();
        end
        launch_x = 10'd400;
        launch_y = 10'd300;
        chk("x_ready_low", 32'(launch_ready), 0);
        chk("x_all_active", 32'(active), 15);
        step();
        step();
        chk("x_held_active", 32'(active), 15);
        chk("x_slot3_x", 32'(sx(3)), 250);
        push_ev(2, 200, 200);
        frame(4'b0100);
        chk("x_ready_during_boom", 32'(launch_ready), 0);
        chk("x_boom_slot", 32'(boom_slot), 2);
        step();
        chk("x_ready_after_hs", 32'(launch_ready), 1);
        chk("x_active_gap", 32'(active), 11);
        step();
        launch_valid = 1'b0;
        chk("x_refill_active", 32'(active), 15);
        chk("x_refill_x", 32'(sx(2)), 400);
        chk("x_refill_y", 32'(sy(2)), 300);

        // simultaneous booms under backpressure
        boom_ready = 1'b0;
        push_ev(0, 100, 200);
        push_ev(3, 250, 200);
        frame(4'b1001);
        for (int k = 0; k < 5; k++) begin
            chk("s_hold_valid", 32'(boom_valid), 1);
            chk("s_hold_slot", 32'(boom_slot), 0);
            chk("s_hold_x", 32'(boom_x), 100);
            step();
        end
        boom_ready = 1'b1;
        step();
        chk("s_second_slot", 32'(boom_slot), 3);
        chk("s_second_x", 32'(boom_x), 250);
        step();
        chk("s_drained", 32'(boom_valid), 0);
        chk("s_active", 32'(active), 6);

        // reset mid-flight with a pending event
        launch(120, 250, 0, 0);
        launch(500, 250, 0, 0);
        chk("r_active4", 32'(active), 15);
        boom_ready = 1'b0;
        frame(4'b0010);
        chk("r_pending", 32'(boom_valid), 1);
        chk("r_active3", 32'(active), 13);
        draw_x = 10'd396;
        draw_y = 10'd292;
        #1;
        chk("r_draw_hit", 32'(draw_bomb), 1);
        chk("r_draw_slot", 32'(draw_slot), 2);
        chk("r_draw_addr", 32'(addr_bomb), 13);
        #2;
        reset_n = 1'b0;
        #1;
        chk("r_active0", 32'(active), 0);
        chk("r_boom_drop", 32'(boom_valid), 0);
        chk("r_draw_off", 32'(draw_bomb), 0);
        #3;
        reset_n = 1'b1;
        boom_ready = 1'b1;
        step();
        chk("r_ready", 32'(launch_ready), 1);

`ifdef PROJ_WIND_EN
        wind = 4'sd2;
        launch(300, 300, 0, 0);
        frames(6);
        chk("w_x6", 32'(sx(0)), 300);
        frames(1);
        chk("w_x7", 32'(sx(0)), 302);
        push_ev(0, 302, 301);
        frame(4'b0001);
        step();
        wind = 4'sd0;
`endif

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
